instr_encoder: RTL
==================

# instr_encoder

Sequential MIPS instruction encoder: the write-side counterpart of the field-extraction decoder. It accepts instruction fields over a valid/ready handshake and packs them into 32-bit R/I/J-format words. Each legal word is tagged with a sequential byte address and buffered in a small FIFO for an instruction-memory loader or testbench stimulus source. It sits between an assembler/host front end and the instruction memory write port.

## Interface

Parameters:
- ADDR_W, 32, width of the address tag
- BASE_ADDR, 0, address assigned to the first word after reset or flush
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  field set presented
- in_ready  out  1  encoder can accept
- fmt  in  2  format: 00 R, 01 I, 10 J, 11 illegal
- opcode  in  6  primary opcode (ignored for R)
- rs, rt, rd, shamt  in  5 each  register/shift fields
- funct  in  6  R-type function
- immediate  in  16  I-type immediate
- target  in  26  J-type target
- flush  in  1  synchronous clear of FIFO, address counter, error
- out_valid  out  1  head word available
- out_ready  in  1  consumer takes head word
- out_instr  out  32  encoded word at FIFO head
- out_addr  out  ADDR_W  byte address of head word
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky: an illegal field set was accepted

## Operation

- Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}; the opcode input is ignored.
  - I: {opcode, rs, rt, immediate}.
  - J: {opcode, target}.
- Illegal cases:
  - fmt=11.
  - fmt=I with opcode=000000.
  - fmt=J with opcode not 000010 or 000011.
- Illegal field sets still complete the handshake; they are dropped (not pushed, address not advanced) and err is set.
- Address counter starts at BASE_ADDR and advances by 4 on each legal push, wrapping modulo 2^ADDR_W. Each pushed word stores the counter value current at its push.
- FIFO:
  - Push = in_valid & in_ready & legal.
  - Pop = out_valid & out_ready.
  - Read/write pointers wrap modulo DEPTH.
- in_ready = !full & !flush.
  - When full, no push is accepted, even if a pop occurs the same cycle; in_ready is combinational from registered state.
- When count=0: out_valid=0, out_instr=0, out_addr=0.
- flush has priority over push and pop. On the next edge: count=0, pointers=0, address counter=BASE_ADDR, err=0.
- err is cleared only by reset or flush.

## Timing

- Reset (async assert, sync-deasserted externally):
  - out_valid=0, out_instr=0, out_addr=0, count=0, err=0.
  - in_ready=1 once rst_n=1; address counter=BASE_ADDR.
  - Reset mid-transfer discards all buffered words.
- Latency: a field set accepted at edge N appears at the head (out_valid=1) after edge N. There is no combinational fall-through from in_* to out_*.
- Output stability: out_instr/out_addr hold while out_valid=1 and out_ready=0.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both occur.
- Empty: a pop is impossible since out_valid=0; a push alone moves count to 1.
- Full: in_ready=0. A pop alone makes count=DEPTH-1 and in_ready=1 the next cycle.
- err rises on the edge that accepts the illegal set.
- Throughput: one word per cycle sustained when out_ready=1.

## Test plan

- Reset, then R-type push:
  - Stimulus: fmt=00, rs=8, rt=9, rd=10, shamt=0, funct=0x20.
  - Response: next cycle out_valid=1, out_instr=0x01095020, out_addr=BASE_ADDR (0).
- Mixed-format stream with out_ready=1:
  - Stimulus: I (opcode=0x08, rs=0, rt=8, imm=5), I (opcode=0x23, rs=8, rt=9, imm=4), J (opcode=0x02, target=0x0100000).
  - Response: 0x20080005 @0, 0x8D090004 @4, 0x08100000 @8, each one cycle after acceptance.
- Illegal input and flush:
  - Stimulus: fmt=J, opcode=0x08, then a legal R push.
  - Response: the illegal set is accepted and err=1. The R word gets address 0, not 4. err stays 1 until flush; flush returns err=0 and count=0.
- Backpressure, DEPTH=4:
  - Stimulus: hold out_ready=0 and push 5 sets.
  - Response: count=4, in_ready=0, and the 5th set waits. Head stays at the first word. One pop raises in_ready; order is preserved.
- Address wrap and async reset:
  - Stimulus: ADDR_W=4, BASE_ADDR=8, push 3 words; then assert rst_n=0 mid-stream with count=2.
  - Response: addresses 8, 12, 0. After reset, out_valid=0 and count=0 immediately (async), and the next word gets address 8.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS R/I/J field sets into 32-bit words, tags each
// legal word with a running byte address and queues it in a small FIFO.
// Illegal field sets are accepted and dropped, and they raise a sticky err.
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               fmt,
   input  logic [5:0]               opcode,
   input  logic [4:0]               rs,
   input  logic [4:0]               rt,
   input  logic [4:0]               rd,
   input  logic [4:0]               shamt,
   input  logic [5:0]               funct,
   input  logic [15:0]              immediate,
   input  logic [25:0]              target,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]       mem_instr_q [DEPTH];
   logic [31:0]       mem_instr_d [DEPTH];
   logic [ADDR_W-1:0] mem_addr_q  [DEPTH];
   logic [ADDR_W-1:0] mem_addr_d  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic              err_q, err_d;

   logic [31:0] word;
   logic        legal;
   logic        full;
   logic        accept;
   logic        push;
   logic        pop;

   // Field packing and legality check for the presented field set.
   always_comb begin
      word  = '0;
      legal = 1'b0;
      case (fmt)
         2'b00: begin
            word  = {6'b000000, rs, rt, rd, shamt, funct};
            legal = 1'b1;
         end
         2'b01: begin
            word  = {opcode, rs, rt, immediate};
            legal = (opcode != 6'b000000);
         end
         2'b10: begin
            word  = {opcode, target};
            legal = (opcode == 6'b000010) || (opcode == 6'b000011);
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

   // Handshake decode; in_ready looks only at registered occupancy so a
   // same-cycle pop never opens a slot while full.
   always_comb begin
      full      = (count_q == CNT_W'(DEPTH));
      in_ready  = !full && !flush;
      accept    = in_valid && in_ready;
      push      = accept && legal;
      out_valid = (count_q != '0);
      pop       = out_valid && out_ready;
      out_instr = out_valid ? mem_instr_q[rd_ptr_q] : '0;
      out_addr  = out_valid ? mem_addr_q[rd_ptr_q] : '0;
      count     = count_q;
      err       = err_q;
   end

   // Next-state for FIFO storage, pointers, address counter and err; flush wins.
   always_comb begin
      mem_instr_d = mem_instr_q;
      mem_addr_d  = mem_addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      addr_cnt_d  = addr_cnt_q;
      err_d       = err_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         addr_cnt_d = BASE_ADDR;
         err_d      = 1'b0;
      end else begin
         if (push) begin
            mem_instr_d[wr_ptr_q] = word;
            mem_addr_d[wr_ptr_q]  = addr_cnt_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            addr_cnt_d            = addr_cnt_q + ADDR_W'(4);
         end
         if (accept && !legal) begin
            err_d = 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; reset discards any buffered words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_instr_q[i] <= '0;
            mem_addr_q[i]  <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         addr_cnt_q <= BASE_ADDR;
         err_q      <= 1'b0;
      end else begin
         mem_instr_q <= mem_instr_d;
         mem_addr_q  <= mem_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         addr_cnt_q  <= addr_cnt_d;
         err_q       <= err_d;
      end
   end

endmodule
